// File: rtl/my_pkg.sv
// Shared types and constants for the data-memory access stage.
// Control struct, state enum, funct3 encodings and the alignment-fault rule.
package my_pkg;

  typedef struct packed {
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic [2:0] funct3;
  } MEM_ctrl;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// load lane selection with sign or zero extension.
module load_store_align
  import my_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [15:0] lane;

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    lane      = 16'(rdata >> {addr_lo, 3'b000});
    load_data = rdata;

    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase

    case (funct3)
      LB:      load_data = {{24{lane[7]}}, lane[7:0]};
      LH:      load_data = {{16{lane[15]}}, lane[15:0]};
      LBU:     load_data = {24'h0, lane[7:0]};
      LHU:     load_data = {16'h0, lane[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues one data-memory request at a time, waits for
// grant / read return, and registers the result toward write-back.
module mem_access_unit
  import my_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        EX_valid,
  input  logic [31:0] EX_ALUResult,
  input  logic [31:0] EX_reg_data_2,
  input  MEM_ctrl     EX_in_MEM,
  input  logic [4:0]  EX_rd,
  output logic        DM_req,
  output logic        DM_we,
  output logic [31:0] DM_addr,
  output logic [3:0]  DM_be,
  output logic [31:0] DM_wdata,
  input  logic        DM_gnt,
  input  logic        DM_rvalid,
  input  logic [31:0] DM_rdata,
  output logic        MEM_valid,
  output logic [31:0] MEM_ALU_res,
  output logic [31:0] MEM_load_data,
  output logic [4:0]  MEM_rd,
  output logic        MEM_RegWrite,
  output logic        MEM_stall,
  output logic        MEM_misaligned
);

  mem_state_t state, state_nxt;

  logic [31:0] inf_addr, inf_sdata;
  logic [2:0]  inf_f3;
  logic [4:0]  inf_rd;
  logic        inf_we, inf_rw;

  logic [31:0] park_alu, park_ld;
  logic [4:0]  park_rd;
  logic        park_rw;

  logic        accept, is_mem, is_mis, go_mem;
  logic        cmp, cmp_rw;
  logic [31:0] cmp_ld;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld;

  assign MEM_stall = (state != IDLE);
  assign accept    = EN & EX_valid & ~MEM_stall;
  assign is_mem    = EX_in_MEM.MemRead | EX_in_MEM.MemWrite;
  assign is_mis    = is_mem & misaligned(EX_in_MEM.funct3[1:0], EX_ALUResult[1:0]);
  assign go_mem    = accept & is_mem & ~is_mis;

  assign cmp_ld = inf_we ? '0 : al_ld;
  assign cmp_rw = ~inf_we & inf_rw;

  load_store_align u_align (
    .funct3     (inf_f3),
    .addr_lo    (inf_addr[1:0]),
    .store_data (inf_sdata),
    .rdata      (DM_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_ld)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request fields come only from the in-flight register, so they stay
  // stable for however long the grant takes.
  always_comb begin
    state_nxt = state;
    cmp       = 1'b0;
    DM_req    = 1'b0;
    DM_we     = 1'b0;
    DM_addr   = '0;
    DM_be     = '0;
    DM_wdata  = '0;
    case (state)
      IDLE: if (go_mem) state_nxt = REQ;
      REQ: begin
        DM_req   = 1'b1;
        DM_we    = inf_we;
        DM_addr  = {inf_addr[31:2], 2'b00};
        DM_be    = al_be;
        DM_wdata = al_wdata;
        if (DM_gnt) begin
          if (inf_we) begin
            cmp       = 1'b1;
            state_nxt = EN ? IDLE : DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: if (DM_rvalid) begin
        cmp       = 1'b1;
        state_nxt = EN ? IDLE : DONE;
      end
      DONE: if (EN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      inf_addr  <= '0;
      inf_sdata <= '0;
      inf_f3    <= '0;
      inf_rd    <= '0;
      inf_we    <= 1'b0;
      inf_rw    <= 1'b0;
      park_alu  <= '0;
      park_ld   <= '0;
      park_rd   <= '0;
      park_rw   <= 1'b0;
    end else begin
      if (go_mem) begin
        inf_addr  <= EX_ALUResult;
        inf_sdata <= EX_reg_data_2;
        inf_f3    <= EX_in_MEM.funct3;
        inf_rd    <= EX_rd;
        inf_we    <= EX_in_MEM.MemWrite;
        inf_rw    <= EX_in_MEM.RegWrite;
      end
      if (cmp && !EN) begin
        park_alu <= inf_addr;
        park_ld  <= cmp_ld;
        park_rd  <= inf_rd;
        park_rw  <= cmp_rw;
      end
    end
  end

  // The fault flag clears every cycle regardless of EN so it stays a pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      MEM_valid      <= 1'b0;
      MEM_ALU_res    <= '0;
      MEM_load_data  <= '0;
      MEM_rd         <= '0;
      MEM_RegWrite   <= 1'b0;
      MEM_misaligned <= 1'b0;
    end else begin
      MEM_misaligned <= 1'b0;
      if (EN) begin
        MEM_valid    <= 1'b0;
        MEM_RegWrite <= 1'b0;
        if (accept && !go_mem) begin
          MEM_valid      <= 1'b1;
          MEM_ALU_res    <= EX_ALUResult;
          MEM_load_data  <= '0;
          MEM_rd         <= EX_rd;
          MEM_RegWrite   <= ~is_mem & EX_in_MEM.RegWrite;
          MEM_misaligned <= is_mis;
        end else if (cmp) begin
          MEM_valid     <= 1'b1;
          MEM_ALU_res   <= inf_addr;
          MEM_load_data <= cmp_ld;
          MEM_rd        <= inf_rd;
          MEM_RegWrite  <= cmp_rw;
        end else if (state == DONE) begin
          MEM_valid     <= 1'b1;
          MEM_ALU_res   <= park_alu;
          MEM_load_data <= park_ld;
          MEM_rd        <= park_rd;
          MEM_RegWrite  <= park_rw;
        end
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state changes on rising edge.
REQ-002 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port EN, input, 1, pipeline enable; gates acceptance and output-register update.
REQ-004 SHALL have port EX_valid, input, 1, EX-stage instruction present.
REQ-005 SHALL have port EX_ALUResult, input, 32, effective address or ALU result.
REQ-006 SHALL have port EX_reg_data_2, input, 32, store data.
REQ-007 SHALL have port EX_in_MEM, input, MEM_ctrl, fields MemRead, MemWrite, RegWrite, funct3[2:0].
REQ-008 SHALL have port EX_rd, input, 5, destination register.
REQ-009 SHALL have ports DM_req, DM_we (output, 1), DM_addr (output, 32, word-aligned), DM_be (output, 4), DM_wdata (output, 32); data-memory request.
REQ-010 SHALL have ports DM_gnt, DM_rvalid (input, 1), DM_rdata (input, 32); data-memory grant and read return.
REQ-011 SHALL have ports MEM_valid (output, 1), MEM_ALU_res (output, 32), MEM_load_data (output, 32), MEM_rd (output, 5), MEM_RegWrite (output, 1); registered WB-side result.
REQ-012 SHALL have ports MEM_stall (output, 1), upstream hold, and MEM_misaligned (output, 1), one-cycle fault pulse.

Function
REQ-013 SHALL accept EX inputs in a cycle where EN=1, EX_valid=1 and MEM_stall=0.
REQ-014 SHALL drive MEM_stall=1 whenever state is not IDLE; combinational from state only.
REQ-015 SHALL implement states IDLE, REQ, WAIT, DONE (mem_state_t).
REQ-016 IDLE: accepted op with MemRead or MemWrite and aligned address -> capture into in-flight register, go REQ; any other accepted op -> loaded into output register next edge, MEM_valid=1, stay IDLE.
REQ-017 REQ: DM_req=1; DM_we, DM_addr={addr[31:2],2'b00}, DM_be, DM_wdata held stable from in-flight register until DM_gnt=1.
REQ-018 REQ with DM_gnt=1: store -> completion; load -> WAIT; DM_req=0 next cycle.
REQ-019 WAIT: DM_req=0; DM_rvalid=1 -> capture DM_rdata, completion; DM_rvalid in IDLE or REQ SHALL be ignored.
REQ-020 Completion with EN=1 -> output register loaded, MEM_valid=1, go IDLE; with EN=0 -> result parked, go DONE; DONE with EN=1 -> output loaded, go IDLE.
REQ-021 Latency: store accepted T, gnt at T+1 -> MEM_valid at T+2; load accepted T, gnt T+1, rvalid T+2 -> MEM_valid at T+3; non-memory op -> MEM_valid at T+1.
REQ-022 Output register with EN=1 and nothing to load SHALL set MEM_valid=0, MEM_RegWrite=0; with EN=0 SHALL hold.
REQ-023 Stores: SB DM_be=0001<<addr[1:0], data byte replicated x4; SH DM_be=0011<<addr[1:0], halfword replicated x2; SW DM_be=1111.
REQ-024 Loads: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass; result on MEM_load_data; MEM_ALU_res carries the address.
REQ-025 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no DM request; MEM_misaligned=1 for one cycle after acceptance; MEM_valid=1 with MEM_RegWrite=0; state stays IDLE.
REQ-026 Stores and misaligned ops SHALL output MEM_RegWrite=0; loads and ALU ops pass EX_in_MEM.RegWrite.
REQ-027 At most one memory op in flight; no new DM_req before completion.

Reset
REQ-028 RST=1 SHALL force state IDLE, DM_req=0, DM_we=0, DM_be=0, MEM_valid=0, MEM_RegWrite=0, MEM_misaligned=0, all data outputs 0.
REQ-029 RST mid-operation (REQ/WAIT/DONE) SHALL abandon the op; later DM_gnt/DM_rvalid for it ignored.
REQ-030 RST SHALL take priority over EN and all handshake inputs.

Structure
REQ-031 MEM_ctrl struct, mem_state_t enum and funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) SHALL live in my_pkg.
REQ-032 Byte-lane alignment/extension logic SHALL be a combinational sub-module load_store_align.

Verification
REQ-033 SW addr 0x100 data 0xDEADBEEF, gnt on first REQ cycle -> DM_be=1111, DM_addr=0x100, MEM_valid at T+2, MEM_RegWrite=0.
REQ-034 LB addr 0x203, rdata 0x80FF1234, gnt T+1, rvalid T+3 -> MEM_load_data=0xFFFFFF80, MEM_stall high T+1..T+3, MEM_valid at T+4.
REQ-035 LHU addr 0x202 rdata 0x80FF1234 -> 0x000080FF; SH addr 0x102 data 0x0000ABCD -> DM_be=1100, DM_wdata=0xABCDABCD.
REQ-036 LW addr 0x101 -> DM_req never asserted, MEM_misaligned pulse at T+1, MEM_RegWrite=0.
REQ-037 Load rvalid while EN=0 -> state DONE, MEM_valid held; EN=1 next -> MEM_valid=1, IDLE.
REQ-038 RST asserted in WAIT, stale rvalid after -> outputs zero, state IDLE, no MEM_valid.
